// File: rtl/kgp_exec_branch_unit_if.sv
// Operand/result bundle between the KGP-RISC decode stage and the execute/branch unit.
interface kgp_exec_branch_unit_if;
  logic [2:0]  alu_op_i;
  logic [5:0]  func_code_i;
  logic [31:0] instruction_i;
  logic [31:0] pc_in_i;
  logic [31:0] input1_i;
  logic [31:0] input2_i;
  logic [4:0]  shamt_i;
  logic [31:0] alu_out_o;
  logic [2:0]  flags_o;
  logic [31:0] pc_out_o;
  logic        link_o;

  modport master (
    output alu_op_i, func_code_i, instruction_i, pc_in_i, input1_i, input2_i, shamt_i,
    input  alu_out_o, flags_o, pc_out_o, link_o
  );

  modport slave (
    input  alu_op_i, func_code_i, instruction_i, pc_in_i, input1_i, input2_i, shamt_i,
    output alu_out_o, flags_o, pc_out_o, link_o
  );
endinterface

// File: rtl/kgp_exec_branch_unit.sv
// KGP-RISC execute stage: ALU control decode, ALU with flags, carry register and next-PC logic.
// Define ALU_VAR_SHIFT_EN to implement the SLLV/SRLV/SRAV variable shifts.
module kgp_exec_branch_unit (
  input logic clk,
  input logic rst,
  kgp_exec_branch_unit_if.slave bus
);

  typedef enum logic [3:0] {
    CTL_ADD  = 4'b0000,
    CTL_COMP = 4'b0001,
    CTL_AND  = 4'b0010,
    CTL_XOR  = 4'b0011,
    CTL_SLL  = 4'b0100,
    CTL_SRL  = 4'b0101,
    CTL_SLLV = 4'b0110,
    CTL_SRLV = 4'b0111,
    CTL_SRA  = 4'b1000,
    CTL_SRAV = 4'b1001,
    CTL_NOP  = 4'b1111
  } ctl_e;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_COMPI = 6'b000010;
  localparam logic [5:0] OP_B     = 6'b010000;
  localparam logic [5:0] OP_BR    = 6'b010001;
  localparam logic [5:0] OP_BLTZ  = 6'b010010;
  localparam logic [5:0] OP_BZ    = 6'b010011;
  localparam logic [5:0] OP_BNZ   = 6'b010100;
  localparam logic [5:0] OP_BL    = 6'b010101;
  localparam logic [5:0] OP_BCY   = 6'b010110;
  localparam logic [5:0] OP_BNCY  = 6'b010111;

  ctl_e        ctl;
  logic [31:0] aluRes;
  logic        aluCarry;
  logic        carry_q;
  logic        carry_d;
  logic [5:0]  opcode;
  logic [31:0] seqPc;
  logic [31:0] jTarget;
  logic [31:0] rTarget;
  logic [31:0] nextPc;

  assign opcode = bus.instruction_i[31:26];

  always_comb begin
    ctl = CTL_NOP;
    case (bus.alu_op_i)
      3'b001: ctl = CTL_ADD;
      3'b010: ctl = CTL_COMP;
      3'b000: begin
        case (bus.func_code_i)
          6'h00:   ctl = CTL_ADD;
          6'h01:   ctl = CTL_COMP;
          6'h02:   ctl = CTL_AND;
          6'h03:   ctl = CTL_XOR;
          6'h04:   ctl = CTL_SLL;
          6'h05:   ctl = CTL_SRL;
          6'h06:   ctl = CTL_SLLV;
          6'h07:   ctl = CTL_SRLV;
          6'h08:   ctl = CTL_SRA;
          6'h09:   ctl = CTL_SRAV;
          default: ctl = CTL_NOP;
        endcase
      end
      default: ctl = CTL_NOP;
    endcase
  end

  // COMP negates input2 alone; its carry is the carry-out of ~in2 + 1.
  always_comb begin
    aluRes   = 32'd0;
    aluCarry = 1'b0;
    case (ctl)
      CTL_ADD:  {aluCarry, aluRes} = {1'b0, bus.input1_i} + {1'b0, bus.input2_i};
      CTL_COMP: {aluCarry, aluRes} = {1'b0, ~bus.input2_i} + 33'd1;
      CTL_AND:  aluRes = bus.input1_i & bus.input2_i;
      CTL_XOR:  aluRes = bus.input1_i ^ bus.input2_i;
      CTL_SLL:  aluRes = bus.input1_i << bus.shamt_i;
      CTL_SRL:  aluRes = bus.input1_i >> bus.shamt_i;
      CTL_SRA:  aluRes = 32'($signed(bus.input1_i) >>> bus.shamt_i);
`ifdef ALU_VAR_SHIFT_EN
      CTL_SLLV: aluRes = bus.input1_i << bus.input2_i[4:0];
      CTL_SRLV: aluRes = bus.input1_i >> bus.input2_i[4:0];
      CTL_SRAV: aluRes = 32'($signed(bus.input1_i) >>> bus.input2_i[4:0]);
`endif
      default:  aluRes = 32'd0;
    endcase
  end

  assign bus.alu_out_o = aluRes;
  assign bus.flags_o   = {aluCarry, (aluRes == 32'd0), aluRes[31]};

  always_comb begin
    carry_d = carry_q;
    if (((opcode == OP_R) || (opcode == OP_ADDI) || (opcode == OP_COMPI)) &&
        ((ctl == CTL_ADD) || (ctl == CTL_COMP)))
      carry_d = aluCarry;
  end

  always_ff @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign seqPc   = bus.pc_in_i + 32'd4;
  assign jTarget = {4'b0000, bus.instruction_i[25:0], 2'b00};
  assign rTarget = seqPc + {{14{bus.instruction_i[15]}}, bus.instruction_i[15:0], 2'b00};

  // bcy/bncy look at the carry left behind by an earlier instruction, not the current ALU flag.
  always_comb begin
    nextPc = seqPc;
    case (opcode)
      OP_B, OP_BL: nextPc = jTarget;
      OP_BCY:      nextPc = carry_q ? jTarget : seqPc;
      OP_BNCY:     nextPc = carry_q ? seqPc : jTarget;
      OP_BLTZ:     nextPc = bus.input1_i[31] ? rTarget : seqPc;
      OP_BZ:       nextPc = (bus.input1_i == 32'd0) ? rTarget : seqPc;
      OP_BNZ:      nextPc = (bus.input1_i != 32'd0) ? rTarget : seqPc;
      OP_BR:       nextPc = bus.input1_i;
      default:     nextPc = seqPc;
    endcase
    if (rst) nextPc = 32'd0;
  end

  assign bus.pc_out_o = nextPc;
  assign bus.link_o   = (opcode == OP_BL) & ~rst;

endmodule

// File: tb/tb_kgp_exec_branch_unit.sv
// Scoreboard bench for kgp_exec_branch_unit: expected {alu_out, flags, pc_out, link} queued per vector.
module tb_kgp_exec_branch_unit;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  kgp_exec_branch_unit_if bus ();

  kgp_exec_branch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [67:0] exp;
  } vec_t;

  logic [67:0] expQ[$];

  function automatic vec_t mk(string name, logic r, logic [2:0] op, logic [5:0] fn,
                              logic [31:0] ins, logic [31:0] pc, logic [31:0] a,
                              logic [31:0] b, logic [4:0] sh, logic [31:0] eAlu,
                              logic [2:0] eFl, logic [31:0] ePc, logic eLink);
    vec_t v;
    v.name = name; v.rst = r; v.op = op; v.fn = fn; v.ins = ins; v.pc = pc;
    v.a = a; v.b = b; v.sh = sh;
    v.exp = {eAlu, eFl, ePc, eLink};
    return v;
  endfunction

  // ALU vector: R-type/addi/compi encoding chosen from alu_op, pc 0x1000 falls through to 0x1004.
  function automatic vec_t aluVec(string name, logic [2:0] op, logic [5:0] fn, logic [31:0] a,
                                  logic [31:0] b, logic [4:0] sh, logic [31:0] eAlu,
                                  logic [2:0] eFl);
    logic [5:0] opc;
    opc = (op == 3'b001) ? 6'b000001 : (op == 3'b010) ? 6'b000010 : 6'b000000;
    return mk(name, 1'b0, op, fn, {opc, 10'd0, sh, 5'd0, fn}, 32'h1000, a, b, sh,
              eAlu, eFl, 32'h1004, 1'b0);
  endfunction

  // Branch vector: ALU held at NOP so its outputs are 0 with only the zero flag set.
  function automatic vec_t brVec(string name, logic [31:0] ins, logic [31:0] pc,
                                 logic [31:0] a, logic [31:0] ePc, logic eLink);
    return mk(name, 1'b0, 3'b111, 6'h00, ins, pc, a, 32'h0, 5'd0, 32'h0, 3'b010, ePc, eLink);
  endfunction

  task automatic drive(input vec_t v);
    rst               = v.rst;
    bus.alu_op_i      = v.op;
    bus.func_code_i   = v.fn;
    bus.instruction_i = v.ins;
    bus.pc_in_i       = v.pc;
    bus.input1_i      = v.a;
    bus.input2_i      = v.b;
    bus.shamt_i       = v.sh;
    expQ.push_back(v.exp);
  endtask

  task automatic test_reset();
    vec_t        v[$];
    logic [67:0] got;
    logic [67:0] want;
    v.push_back(mk("reset_override", 1'b1, 3'b001, 6'h00, 32'h54000040, 32'h1000,
                   32'd5, 32'd7, 5'd0, 32'd12, 3'b000, 32'h0, 1'b0));
    v.push_back(brVec("reset_bcy_clear", 32'h58000040, 32'h200, 32'h0, 32'h204, 1'b0));
    v.push_back(brVec("reset_bncy_clear", 32'h5C000040, 32'h200, 32'h0, 32'h100, 1'b0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got  = {bus.alu_out_o, bus.flags_o, bus.pc_out_o, bus.link_o};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL %s: got alu=%h flags=%b pc=%h link=%b, want alu=%h flags=%b pc=%h link=%b",
                 v[i].name, got[67:36], got[35:33], got[32:1], got[0],
                 want[67:36], want[35:33], want[32:1], want[0]);
      end
    end
  endtask

  task automatic test_alu();
    vec_t        v[$];
    logic [67:0] got;
    logic [67:0] want;
    v.push_back(aluVec("add_5_7",     3'b000, 6'h00, 32'd5, 32'd7, 5'd0, 32'd12, 3'b000));
    v.push_back(aluVec("add_wrap",    3'b000, 6'h00, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0, 3'b110));
    v.push_back(aluVec("comp_3",      3'b010, 6'h00, 32'd99, 32'd3, 5'd0, 32'hFFFFFFFD, 3'b001));
    v.push_back(aluVec("comp_zero",   3'b010, 6'h00, 32'd1, 32'd0, 5'd0, 32'h0, 3'b110));
    v.push_back(aluVec("rcomp_1",     3'b000, 6'h01, 32'd9, 32'd1, 5'd0, 32'hFFFFFFFF, 3'b001));
    v.push_back(aluVec("and",         3'b000, 6'h02, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 3'b000));
    v.push_back(aluVec("xor_self",    3'b000, 6'h03, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h0, 3'b010));
    v.push_back(aluVec("sll_31",      3'b000, 6'h04, 32'd1, 32'd0, 5'd31, 32'h80000000, 3'b001));
    v.push_back(aluVec("srl_4",       3'b000, 6'h05, 32'h80000000, 32'd0, 5'd4, 32'h08000000, 3'b000));
    v.push_back(aluVec("sra_4",       3'b000, 6'h08, 32'h80000000, 32'd0, 5'd4, 32'hF8000000, 3'b001));
    v.push_back(aluVec("bad_func",    3'b000, 6'h0A, 32'd5, 32'd7, 5'd0, 32'h0, 3'b010));
    v.push_back(aluVec("nop_aluop",   3'b101, 6'h00, 32'd5, 32'd7, 5'd0, 32'h0, 3'b010));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got  = {bus.alu_out_o, bus.flags_o, bus.pc_out_o, bus.link_o};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL %s: got alu=%h flags=%b pc=%h link=%b, want alu=%h flags=%b pc=%h link=%b",
                 v[i].name, got[67:36], got[35:33], got[32:1], got[0],
                 want[67:36], want[35:33], want[32:1], want[0]);
      end
    end
  endtask

  task automatic test_var_shift();
    vec_t        v[$];
    logic [67:0] got;
    logic [67:0] want;
`ifdef ALU_VAR_SHIFT_EN
    v.push_back(aluVec("sllv", 3'b000, 6'h06, 32'd3, 32'h21, 5'd0, 32'd6, 3'b000));
    v.push_back(aluVec("srlv", 3'b000, 6'h07, 32'h80000000, 32'h1F, 5'd0, 32'd1, 3'b000));
    v.push_back(aluVec("srav", 3'b000, 6'h09, 32'h80000000, 32'd4, 5'd0, 32'hF8000000, 3'b001));
`else
    v.push_back(aluVec("sllv_off", 3'b000, 6'h06, 32'd3, 32'h21, 5'd0, 32'h0, 3'b010));
    v.push_back(aluVec("srlv_off", 3'b000, 6'h07, 32'h80000000, 32'h1F, 5'd0, 32'h0, 3'b010));
    v.push_back(aluVec("srav_off", 3'b000, 6'h09, 32'h80000000, 32'd4, 5'd0, 32'h0, 3'b010));
`endif
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got  = {bus.alu_out_o, bus.flags_o, bus.pc_out_o, bus.link_o};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL %s: got alu=%h flags=%b pc=%h link=%b, want alu=%h flags=%b pc=%h link=%b",
                 v[i].name, got[67:36], got[35:33], got[32:1], got[0],
                 want[67:36], want[35:33], want[32:1], want[0]);
      end
    end
  endtask

  task automatic test_carry_branch();
    vec_t        v[$];
    logic [67:0] got;
    logic [67:0] want;
    v.push_back(aluVec("cy_set_add", 3'b000, 6'h00, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0, 3'b110));
    v.push_back(brVec("bcy_taken",    32'h58000040, 32'h300, 32'h0, 32'h100, 1'b0));
    v.push_back(brVec("bncy_not",     32'h5C000040, 32'h300, 32'h0, 32'h304, 1'b0));
    v.push_back(aluVec("cy_clr_add", 3'b000, 6'h00, 32'd5, 32'd7, 5'd0, 32'd12, 3'b000));
    v.push_back(brVec("bcy_not",      32'h58000040, 32'h300, 32'h0, 32'h304, 1'b0));
    v.push_back(aluVec("cy_set_addi", 3'b001, 6'h00, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd1, 3'b100));
    v.push_back(brVec("bcy_addi",     32'h58000040, 32'h300, 32'h0, 32'h100, 1'b0));
    v.push_back(aluVec("cy_clr_compi", 3'b010, 6'h00, 32'd0, 32'd5, 5'd0, 32'hFFFFFFFB, 3'b001));
    v.push_back(brVec("bncy_taken",   32'h5C000040, 32'h300, 32'h0, 32'h100, 1'b0));
    v.push_back(aluVec("cy_set_comp", 3'b000, 6'h01, 32'd7, 32'd0, 5'd0, 32'h0, 3'b110));
    v.push_back(mk("lw_no_cy_upd", 1'b0, 3'b001, 6'h00, 32'h0C000000, 32'h500,
                   32'd5, 32'd7, 5'd0, 32'd12, 3'b000, 32'h504, 1'b0));
    v.push_back(brVec("bcy_after_lw", 32'h58000040, 32'h300, 32'h0, 32'h100, 1'b0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got  = {bus.alu_out_o, bus.flags_o, bus.pc_out_o, bus.link_o};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL %s: got alu=%h flags=%b pc=%h link=%b, want alu=%h flags=%b pc=%h link=%b",
                 v[i].name, got[67:36], got[35:33], got[32:1], got[0],
                 want[67:36], want[35:33], want[32:1], want[0]);
      end
    end
  endtask

  task automatic test_branches();
    vec_t        v[$];
    logic [67:0] got;
    logic [67:0] want;
    v.push_back(brVec("bz_taken",    32'h4C00FFFE, 32'h20, 32'h0, 32'h1C, 1'b0));
    v.push_back(brVec("bz_not",      32'h4C00FFFE, 32'h20, 32'h1, 32'h24, 1'b0));
    v.push_back(brVec("bnz_taken",   32'h5000FFFE, 32'h20, 32'h1, 32'h1C, 1'b0));
    v.push_back(brVec("bnz_not",     32'h5000FFFE, 32'h20, 32'h0, 32'h24, 1'b0));
    v.push_back(brVec("bltz_taken",  32'h48000003, 32'h20, 32'h80000000, 32'h30, 1'b0));
    v.push_back(brVec("bltz_not",    32'h48000003, 32'h20, 32'h7FFFFFFF, 32'h24, 1'b0));
    v.push_back(brVec("br",          32'h44000000, 32'h20, 32'h80, 32'h80, 1'b0));
    v.push_back(brVec("b_abs",       32'h43FFFFFF, 32'h20, 32'h0, 32'h0FFFFFFC, 1'b0));
    v.push_back(brVec("bl_link",     32'h54000040, 32'h20, 32'h0, 32'h100, 1'b1));
    v.push_back(brVec("unknown_op",  32'hFC000040, 32'h20, 32'h0, 32'h24, 1'b0));
    v.push_back(brVec("sw_seq",      32'h10000040, 32'h20, 32'h0, 32'h24, 1'b0));
    v.push_back(brVec("pc_wrap",     32'h00000000, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got  = {bus.alu_out_o, bus.flags_o, bus.pc_out_o, bus.link_o};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL %s: got alu=%h flags=%b pc=%h link=%b, want alu=%h flags=%b pc=%h link=%b",
                 v[i].name, got[67:36], got[35:33], got[32:1], got[0],
                 want[67:36], want[35:33], want[32:1], want[0]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    vec_t        v[$];
    logic [67:0] got;
    logic [67:0] want;
    v.push_back(aluVec("mid_cy_set", 3'b000, 6'h00, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0, 3'b110));
    v.push_back(mk("mid_rst_bl", 1'b1, 3'b111, 6'h00, 32'h54000040, 32'h400,
                   32'h0, 32'h0, 5'd0, 32'h0, 3'b010, 32'h0, 1'b0));
    v.push_back(brVec("mid_bcy_cleared", 32'h58000040, 32'h400, 32'h0, 32'h404, 1'b0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got  = {bus.alu_out_o, bus.flags_o, bus.pc_out_o, bus.link_o};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL %s: got alu=%h flags=%b pc=%h link=%b, want alu=%h flags=%b pc=%h link=%b",
                 v[i].name, got[67:36], got[35:33], got[32:1], got[0],
                 want[67:36], want[35:33], want[32:1], want[0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    $display("[TB] starting kgp_exec_branch_unit bench");
    test_reset();
    test_alu();
    test_var_shift();
    test_carry_branch();
    test_branches();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
